// File: rtl/trace_pkg.sv
// Shared constants for the multi-channel synaptic trace bank.
// Holds the mode-bit layout and the saturation ceiling helper.
package trace_pkg;

    localparam int MODE_DECAY_EXP = 0;
    localparam int MODE_ACCUM     = 1;

    // All-ones value of a trace of the given width (width < 64).
    function automatic longint unsigned trace_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/trace_channel.sv
// One synaptic trace: register, saturating spike adder, linear/exponential
// decay datapath and the clear > event > decay > hold priority mux.
module trace_channel
    import trace_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_SHIFT = 2,
    parameter int P_INC   = 2 ** (P_WIDTH - 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic [1:0]         i_mode,
    input  logic               i_clear,
    input  logic               i_event,
    output logic [P_WIDTH-1:0] o_trace,
    output logic               o_active
);

    localparam logic [P_WIDTH-1:0] TRACE_MAX = P_WIDTH'(trace_max(P_WIDTH));
    localparam logic [P_WIDTH:0]   INC_EXT   = (P_WIDTH + 1)'(P_INC);

    logic [P_WIDTH-1:0] trace_q;
    logic [P_WIDTH-1:0] trace_d;
    logic [P_WIDTH:0]   sum_wide;
    logic [P_WIDTH-1:0] sat_sum;
    logic [P_WIDTH-1:0] shifted;
    logic [P_WIDTH-1:0] exp_step;
    logic [P_WIDTH-1:0] decayed;

    // One extra bit of headroom: the carry alone signals saturation.
    assign sum_wide = {1'b0, trace_q} + INC_EXT;
    assign sat_sum  = sum_wide[P_WIDTH] ? TRACE_MAX : sum_wide[P_WIDTH-1:0];

    // Exponential step never drops below 1 so small traces still reach zero.
    assign shifted  = trace_q >> P_SHIFT;
    assign exp_step = (shifted == '0) ? P_WIDTH'(1) : shifted;
    assign decayed  = i_mode[MODE_DECAY_EXP] ? (trace_q - exp_step)
                                             : (trace_q - P_WIDTH'(1));

    always_comb begin
        trace_d = trace_q;
        if (i_clear) begin
            trace_d = '0;
        end else if (i_event) begin
            trace_d = i_mode[MODE_ACCUM] ? sat_sum : TRACE_MAX;
        end else if (i_tick && (trace_q != '0)) begin
            trace_d = decayed;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign o_trace  = trace_q;
    assign o_active = (trace_q != '0);

endmodule

// File: rtl/trace_bank.sv
// P_CH independent synaptic traces sharing one decay prescaler; the traces
// are packed channel-major onto o_trace for the STDP update logic.
module trace_bank
    import trace_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_CH    = 8,
    parameter int P_DIV   = 1,
    parameter int P_SHIFT = 2,
    parameter int P_INC   = 2 ** (P_WIDTH - 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [P_CH-1:0]           i_event,
    input  logic [1:0]                i_mode,
    input  logic                      i_clear,
    output logic [P_CH*P_WIDTH-1:0]   o_trace,
    output logic [P_CH-1:0]           o_active,
    output logic                      o_tick
);

    logic tick;

    generate
        if (P_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int                CNT_W  = $clog2(P_DIV);
            localparam logic [CNT_W-1:0]  P_LAST = CNT_W'(P_DIV - 1);

            logic [CNT_W-1:0] p_q;
            logic [CNT_W-1:0] p_d;

            // Free-running: i_clear deliberately leaves the decay phase alone.
            always_comb begin
                p_d = (p_q == P_LAST) ? '0 : (p_q + CNT_W'(1));
            end

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    p_q <= '0;
                end else begin
                    p_q <= p_d;
                end
            end

            assign tick = (p_q == P_LAST);
        end
    endgenerate

    assign o_tick = tick;

    generate
        for (genvar gi = 0; gi < P_CH; gi++) begin : g_ch
            trace_channel #(
                .P_WIDTH (P_WIDTH),
                .P_SHIFT (P_SHIFT),
                .P_INC   (P_INC)
            ) u_channel (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_tick   (tick),
                .i_mode   (i_mode),
                .i_clear  (i_clear),
                .i_event  (i_event[gi]),
                .o_trace  (o_trace[gi*P_WIDTH +: P_WIDTH]),
                .o_active (o_active[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_trace_bank.sv
// Directed bench for trace_bank (8-bit, 4 channels, divide-by-4, shift 2, inc 64):
// a vector table for the short-range behaviour plus hand sequences for long decays.
module tb_trace_bank;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ev;
    logic [1:0]  mode;
    logic        clr;
    logic [31:0] o_trace;
    logic [3:0]  o_active;
    logic        o_tick;

    int checks = 0;
    int errors = 0;

    logic [1:0] ph = 2'd0;
    bit         tick_edge;

    trace_bank #(
        .P_WIDTH (8),
        .P_CH    (4),
        .P_DIV   (4),
        .P_SHIFT (2),
        .P_INC   (64)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_event  (ev),
        .i_mode   (mode),
        .i_clear  (clr),
        .o_trace  (o_trace),
        .o_active (o_active),
        .o_tick   (o_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic [3:0]  ev;
        logic [1:0]  mode;
        logic        clr;
        logic [31:0] trace;
        logic [3:0]  active;
        logic        tick;
    } vec_t;

    vec_t vecs[19];

    logic [7:0] exp_seq[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle's inputs, take the edge, track the expected prescaler phase.
    task automatic step(input logic r, input logic [3:0] e, input logic [1:0] m, input logic c);
        rst_n = r;
        ev    = e;
        mode  = m;
        clr   = c;
        tick_edge = r && (ph == 2'd3);
        @(posedge clk);
        #1;
        ph = r ? ph + 2'd1 : 2'd0;
    endtask

    function automatic logic [7:0] chv(input int c);
        return o_trace[c*8 +: 8];
    endfunction

    initial begin
        int v;
        int k;

        rst_n = 1'b0;
        ev    = 4'h0;
        mode  = 2'b00;
        clr   = 1'b0;

        exp_seq = '{8'd255, 8'd192, 8'd144, 8'd108, 8'd81, 8'd61, 8'd46, 8'd35, 8'd27,
                    8'd21, 8'd16, 8'd12, 8'd9, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

        //            rst   ev     mode   clr   trace          active tick
        vecs[0]  = '{1'b0, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[4]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b1};
        vecs[6]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
        vecs[7]  = '{1'b1, 4'h1, 2'b00, 1'b0, 32'h0000_00FF, 4'h1, 1'b0};
        vecs[8]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_00FF, 4'h1, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_00FF, 4'h1, 1'b1};
        vecs[10] = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_00FE, 4'h1, 1'b0};
        vecs[11] = '{1'b1, 4'h2, 2'b10, 1'b0, 32'h0000_40FE, 4'h3, 1'b0};
        vecs[12] = '{1'b1, 4'h2, 2'b10, 1'b0, 32'h0000_80FE, 4'h3, 1'b0};
        vecs[13] = '{1'b1, 4'h2, 2'b10, 1'b0, 32'h0000_C0FE, 4'h3, 1'b1};
        vecs[14] = '{1'b1, 4'h2, 2'b10, 1'b0, 32'h0000_FFFD, 4'h3, 1'b0};
        vecs[15] = '{1'b1, 4'h2, 2'b10, 1'b0, 32'h0000_FFFD, 4'h3, 1'b0};
        vecs[16] = '{1'b1, 4'hF, 2'b10, 1'b1, 32'h0000_0000, 4'h0, 1'b0};
        vecs[17] = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b1};
        vecs[18] = '{1'b1, 4'h0, 2'b00, 1'b0, 32'h0000_0000, 4'h0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst_n, vecs[i].ev, vecs[i].mode, vecs[i].clr);
            $display("vec %0d rst_n=%b ev=%b mode=%b clr=%b -> trace=%h active=%b tick=%b",
                     i, vecs[i].rst_n, vecs[i].ev, vecs[i].mode, vecs[i].clr,
                     o_trace, o_active, o_tick);
            chk($sformatf("vec%0d_trace", i), o_trace, vecs[i].trace);
            chk($sformatf("vec%0d_active", i), {28'd0, o_active}, {28'd0, vecs[i].active});
            chk($sformatf("vec%0d_tick", i), {31'd0, o_tick}, {31'd0, vecs[i].tick});
        end

        // Linear set-to-max on ch0 all the way down to zero.
        step(1'b1, 4'h1, 2'b00, 1'b0);
        v = 255;
        chk("lin_start", {24'd0, chv(0)}, 32'(v));
        while (v != 0) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            if (tick_edge) begin
                v--;
                $display("lin tick ch0=%0d active=%b", chv(0), o_active);
            end
            chk("lin_ch0", {24'd0, chv(0)}, 32'(v));
            chk("lin_active0", {31'd0, o_active[0]}, 32'(v != 0));
            chk("lin_others", {8'd0, o_trace[31:8]}, 32'd0);
            chk("lin_tick", {31'd0, o_tick}, 32'(ph == 2'd3));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            chk("lin_floor", o_trace, 32'd0);
        end

        // Exponential decay on ch2.
        step(1'b1, 4'h4, 2'b01, 1'b0);
        k = 0;
        chk("exp_start", {24'd0, chv(2)}, {24'd0, exp_seq[0]});
        while (k < 20) begin
            step(1'b1, 4'h0, 2'b01, 1'b0);
            if (tick_edge) begin
                k++;
                $display("exp tick %0d ch2=%0d", k, chv(2));
            end
            chk("exp_ch2", {24'd0, chv(2)}, {24'd0, exp_seq[k]});
            chk("exp_active2", {31'd0, o_active[2]}, 32'(exp_seq[k] != 8'd0));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'h0, 2'b01, 1'b0);
            chk("exp_floor", o_trace, 32'd0);
        end

        // Bring ch3 to 10, then land events on tick cycles.
        step(1'b1, 4'h8, 2'b01, 1'b0);
        k = 0;
        while (k < 11) begin
            step(1'b1, 4'h0, 2'b01, 1'b0);
            if (tick_edge) k++;
            chk("ebt_exp_ch3", {24'd0, chv(3)}, {24'd0, exp_seq[k]});
        end
        v = 12;
        while (v != 10) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            if (tick_edge) v--;
            chk("ebt_lin_ch3", {24'd0, chv(3)}, 32'(v));
        end
        while (ph != 2'd3) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            chk("ebt_hold_ch3", {24'd0, chv(3)}, 32'd10);
        end
        chk("ebt_tick_before_acc", {31'd0, o_tick}, 32'd1);
        step(1'b1, 4'h8, 2'b10, 1'b0);
        $display("event+tick accumulate ch3=%0d", chv(3));
        chk("ebt_accum", {24'd0, chv(3)}, 32'd74);
        while (ph != 2'd3) begin
            step(1'b1, 4'h0, 2'b10, 1'b0);
            chk("ebt_hold74", {24'd0, chv(3)}, 32'd74);
        end
        chk("ebt_tick_before_set", {31'd0, o_tick}, 32'd1);
        step(1'b1, 4'h8, 2'b00, 1'b0);
        $display("event+tick set-to-max ch3=%0d", chv(3));
        chk("ebt_setmax", {24'd0, chv(3)}, 32'd255);

        // Reset mid-decay wipes traces and restarts the prescaler.
        step(1'b1, 4'hF, 2'b00, 1'b0);
        v = 255;
        chk("rst_pre_all", o_trace, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            if (tick_edge) v--;
            chk("rst_pre_decay", o_trace, {4{8'(v)}});
        end
        step(1'b0, 4'hF, 2'b10, 1'b0);
        $display("mid reset trace=%h active=%b tick=%b", o_trace, o_active, o_tick);
        chk("rst_trace", o_trace, 32'd0);
        chk("rst_active", {28'd0, o_active}, 32'd0);
        chk("rst_tick", {31'd0, o_tick}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'h0, 2'b00, 1'b0);
            $display("post reset cycle %0d tick=%b", i + 1, o_tick);
            chk("rst_cadence", {31'd0, o_tick}, 32'(i == 2 || i == 6));
            chk("rst_zero", o_trace, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_bank.md
# trace_bank

Multi-channel synaptic trace generator for the SNN core: one decaying trace register per presynaptic or postsynaptic neuron. Generalises the single-channel tracer to P_CH channels, programmable decay rate via a shared prescaler, linear or exponential decay, and set-to-max or saturating-accumulate spike response. Sits between the neuron spike outputs and the STDP weight-update logic, which samples `o_trace` each cycle.

## Interface
- `P_WIDTH`, 8: trace width in bits per channel; ≥ 2.
- `P_CH`, 8: number of channels; ≥ 1.
- `P_DIV`, 1: decay prescaler period in clocks; ≥ 1. 1 means decay every cycle.
- `P_SHIFT`, 2: exponential decay shift; 1 ≤ P_SHIFT < P_WIDTH.
- `P_INC`, 2^(P_WIDTH-1): increment added per spike in accumulate mode; 1 ≤ P_INC ≤ 2^P_WIDTH−1.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_event`  in  P_CH  spike strobe per channel; bit c belongs to channel c; one-cycle pulse per spike.
- `i_mode`  in  2  bit0: decay type (0 linear, 1 exponential); bit1: spike response (0 set-to-max, 1 saturating add).
- `i_clear`  in  1  synchronous clear of all traces; does not reset the prescaler.
- `o_trace`  out  P_CH*P_WIDTH  packed traces; channel c at bits [c*P_WIDTH +: P_WIDTH].
- `o_active`  out  P_CH  bit c high iff trace c ≠ 0 (registered view: derived from the register contents).
- `o_tick`  out  1  high during the cycle in which the decay step will be applied at the next edge.

## Operation
- Prescaler `p` counts 0..P_DIV−1 and wraps; `o_tick` = (p == P_DIV−1). When P_DIV = 1, `p` is constant 0 and `o_tick` is constant 1 out of reset.
- Per-channel next-value priority, highest first:
  1. `i_clear`: trace ← 0.
  2. `i_event[c]`: mode bit1 = 0 → trace ← 2^P_WIDTH−1; mode bit1 = 1 → trace ← min(trace + P_INC, 2^P_WIDTH−1), computed at P_WIDTH+1 bits. No decay is applied in the same cycle, even if `o_tick` = 1.
  3. `o_tick` and trace > 0: linear → trace − 1; exponential → trace − max(trace >> P_SHIFT, 1), so traces always reach 0.
  4. Otherwise hold; a trace of 0 never underflows.
- Channels are fully independent; any subset of `i_event` may be high in the same cycle.
- `i_mode` is sampled every cycle. A mode change takes effect on the next edge, with no state cleared.

## Timing
- Reset (`i_rst_n` = 0 at an edge) sets all traces to 0 and `p` to 0, so `o_trace` = 0 and `o_active` = 0. `o_tick` = 1 while in reset only if P_DIV = 1. Reset overrides `i_clear` and `i_event`.
- Reset mid-operation discards all traces and prescaler phase at that edge.
- Latency is one cycle. An event sampled at edge k appears on `o_trace` and `o_active` immediately after edge k.
- Decay cadence: after reset release, the first decay is applied at the P_DIV-th rising edge, then every P_DIV edges.
- `i_clear` leaves the prescaler running, so the decay cadence is phase-continuous across a clear.
- There is no handshake. Consumers sample `o_trace` on any edge.

## Structure
- Package `trace_pkg` holds:
  - mode bit indices `MODE_DECAY_EXP` = 0 and `MODE_ACCUM` = 1;
  - a localparam function for the saturating maximum value.
- Sub-module `trace_channel` (one instance per channel via generate) contains:
  - the trace register;
  - the priority mux;
  - the saturating adder;
  - the decay datapath.
  It takes `o_tick`, `i_mode`, `i_clear` and its own `i_event` bit.
- The prescaler and output packing live in the `trace_bank` top.

## Test plan
All scenarios use P_WIDTH = 8, P_CH = 4, P_DIV = 4, P_SHIFT = 2, P_INC = 64.
- **Reset/cadence:** hold `i_rst_n` = 0 for 3 clocks, then release → traces 0, `o_active` = 0; `o_tick` high on the 4th cycle after release and every 4th cycle thereafter.
- **Linear set-to-max:** mode 00, pulse `i_event[0]` → ch0 = 255 on the next cycle; decrements by 1 per tick; reaches 0 after 255 ticks; `o_active[0]` falls the same cycle it reaches 0; ch1–3 stay 0.
- **Exponential:** mode 01, event on ch2 → values after successive ticks are 255, 192, 144, 108, 81 … and the sequence terminates at 0, with the last steps each subtracting 1.
- **Accumulate/saturate:** mode 10, events on ch1 in 5 consecutive cycles with no tick in between → 64, 128, 192, 255, 255.
- **Event beats tick:** ch3 = 10, event arrives in the same cycle as `o_tick`, mode 10 → ch3 = 74 with no decay; with mode 00 → ch3 = 255.
- **Clear vs event/reset:**
  - `i_clear` together with `i_event` = 4'b1111 → all traces 0, and the tick phase is unchanged.
  - Asserting `i_rst_n` low mid-decay → all traces 0 and the prescaler restarts.
